microop_sequencer: RTL and testbench

Programmable replacement for the hard-wired control FSM of the A/B/C/T/AC bus datapath. It holds a small micro-program of register-transfer operations, runs them one per clock on a start pulse, optionally repeats the sequence, and drives the datapath read/write/ALU enables. It checks every micro-op for bus conflicts and illegal encodings before driving it, and reports completion or error to the top level.

---
 rtl/microop_sequencer_pkg.sv | 44 ++++
 rtl/microop_sequencer_decoder.sv | 66 ++++++
 rtl/microop_sequencer.sv | 134 +++++++++++++
 tb/tb_microop_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/microop_sequencer_pkg.sv
// Shared encodings for the micro-op sequencer: op-word fields, field codes and FSM states.
package microop_sequencer_pkg;

    localparam int SRC_LSB = 5;
    localparam int SRC_W   = 3;
    localparam int DST_LSB = 2;
    localparam int DST_W   = 3;
    localparam int ALU_LSB = 0;
    localparam int ALU_W   = 2;

    localparam logic [7:0] NOP = 8'h00;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_A    = 3'd1,
        SRC_B    = 3'd2,
        SRC_C    = 3'd3,
        SRC_AC   = 3'd4
    } src_e;

    typedef enum logic [2:0] {
        DST_NONE = 3'd0,
        DST_A    = 3'd1,
        DST_B    = 3'd2,
        DST_C    = 3'd3,
        DST_T    = 3'd4,
        DST_AC   = 3'd5
    } dst_e;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_ADD  = 2'd2,
        ALU_ILL  = 2'd3
    } alu_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

endpackage

// File: rtl/microop_sequencer_decoder.sv
// Combinational micro-op decoder: op word -> legality flag and datapath enables.
// Enables are forced to zero whenever the op is illegal.
module microop_decoder
    import microop_sequencer_pkg::*;
(
    input  logic [7:0] op,
    output logic       legal,
    output logic       Ra,
    output logic       Rb,
    output logic       Rc,
    output logic       Rac,
    output logic       Wa,
    output logic       Wb,
    output logic       Wc,
    output logic       Wt,
    output logic       Wac,
    output logic       S,
    output logic       R
);

    logic [SRC_W-1:0] src;
    logic [DST_W-1:0] dst;
    logic [ALU_W-1:0] alu;

    assign src = op[SRC_LSB +: SRC_W];
    assign dst = op[DST_LSB +: DST_W];
    assign alu = op[ALU_LSB +: ALU_W];

    // An ALU op is meaningful only when the result lands in AC, and a write needs a bus source.
    always_comb begin
        legal = (src <= SRC_AC) && (dst <= DST_AC) && (alu != ALU_ILL)
              && ((alu != ALU_PASS) == (dst == DST_AC))
              && ((dst == DST_NONE) || (src != SRC_NONE));
        Ra  = 1'b0;
        Rb  = 1'b0;
        Rc  = 1'b0;
        Rac = 1'b0;
        Wa  = 1'b0;
        Wb  = 1'b0;
        Wc  = 1'b0;
        Wt  = 1'b0;
        Wac = 1'b0;
        S   = 1'b0;
        R   = 1'b0;
        if (legal) begin
            case (src)
                SRC_A:   Ra  = 1'b1;
                SRC_B:   Rb  = 1'b1;
                SRC_C:   Rc  = 1'b1;
                SRC_AC:  Rac = 1'b1;
                default: ;
            endcase
            case (dst)
                DST_A:   Wa  = 1'b1;
                DST_B:   Wb  = 1'b1;
                DST_C:   Wc  = 1'b1;
                DST_T:   Wt  = 1'b1;
                DST_AC:  Wac = 1'b1;
                default: ;
            endcase
            S = (alu == ALU_ADD);
            R = (alu == ALU_SUB);
        end
    end

endmodule

// File: rtl/microop_sequencer.sv
// Programmable micro-op sequencer driving the A/B/C/T/AC bus datapath enables,
// with per-op legality checking, repeat passes, abort and done/error reporting.
module microop_sequencer
    import microop_sequencer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int RW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic [RW-1:0] reps,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] pc,
    output logic          Ra,
    output logic          Rb,
    output logic          Rc,
    output logic          Rac,
    output logic          Wa,
    output logic          Wb,
    output logic          Wc,
    output logic          Wt,
    output logic          Wac,
    output logic          S,
    output logic          R
);

    localparam int LW = AW + 1;

    state_e        state, state_n;
    logic [AW-1:0] pc_n;
    logic [RW-1:0] passes, passes_n;
    logic [LW-1:0] len_q, len_n;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    cur_op;
    logic          op_legal;
    logic          last_op;
    logic [10:0]   dec_en;

    assign cur_op  = mem[pc];
    assign last_op = ({1'b0, pc} == (len_q - LW'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= NOP;
        end else if (prog_we && (state != ST_RUN)) begin
            mem[prog_addr] <= prog_data;
        end
    end

    microop_decoder u_dec (
        .op    (cur_op),
        .legal (op_legal),
        .Ra    (dec_en[10]),
        .Rb    (dec_en[9]),
        .Rc    (dec_en[8]),
        .Rac   (dec_en[7]),
        .Wa    (dec_en[6]),
        .Wb    (dec_en[5]),
        .Wc    (dec_en[4]),
        .Wt    (dec_en[3]),
        .Wac   (dec_en[2]),
        .S     (dec_en[1]),
        .R     (dec_en[0])
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            pc     <= '0;
            passes <= '0;
            len_q  <= '0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            passes <= passes_n;
            len_q  <= len_n;
        end
    end

    // A len beyond DEPTH is clamped so the pc can always reach the last op.
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        passes_n = passes;
        len_n    = len_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_n = ST_DONE;
                    end else begin
                        pc_n     = '0;
                        passes_n = (reps == '0) ? RW'(1) : reps;
                        len_n    = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
                        state_n  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (!op_legal) begin
                    state_n = ST_ERR;
                end else if (last_op) begin
                    pc_n     = '0;
                    passes_n = passes - RW'(1);
                    if (passes == RW'(1)) state_n = ST_DONE;
                end else begin
                    pc_n = pc + AW'(1);
                end
            end
            ST_DONE: state_n = ST_IDLE;
            ST_ERR: begin
                if (start || abort) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign err  = (state == ST_ERR);
    assign {Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wt, Wac, S, R} = busy ? dec_en : 11'b0;

endmodule

// File: tb/tb_microop_sequencer.sv
// Directed self-checking bench for microop_sequencer; inputs change and outputs
// are sampled on the falling clock edge.
module tb_microop_sequencer;

    localparam logic [10:0] E_RA  = 11'h400;
    localparam logic [10:0] E_RAC = 11'h080;
    localparam logic [10:0] E_WC  = 11'h010;
    localparam logic [10:0] E_WT  = 11'h008;
    localparam logic [10:0] E_WAC = 11'h004;
    localparam logic [10:0] E_S   = 11'h002;
    localparam logic [10:0] E_OFF = 11'h000;

    logic       clk = 1'b0;
    logic       reset;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       start;
    logic [4:0] len;
    logic [3:0] reps;
    logic       abort;
    logic       busy, done, err;
    logic [3:0] pc;
    logic       Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wt, Wac, S, R;
    logic [10:0] en;

    int compared   = 0;
    int mismatched = 0;

    logic [10:0] prog3_en [3];

    assign en = {Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wt, Wac, S, R};

    always #5 clk = ~clk;

    microop_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .len       (len),
        .reps      (reps),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pc        (pc),
        .Ra        (Ra),
        .Rb        (Rb),
        .Rc        (Rc),
        .Rac       (Rac),
        .Wa        (Wa),
        .Wb        (Wb),
        .Wc        (Wc),
        .Wt        (Wt),
        .Wac       (Wac),
        .S         (S),
        .R         (R)
    );

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
    endtask

    task automatic loadOp(input logic [3:0] addr, input logic [7:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        stepCycle();
        prog_we   = 1'b0;
    endtask

    // Pulses start for one edge; returns in the first cycle after the sampling edge.
    task automatic applyStimulus(input logic [4:0] l, input logic [3:0] r);
        start = 1'b1;
        len   = l;
        reps  = r;
        stepCycle();
        start = 1'b0;
    endtask

    task automatic pulseAbort();
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
    endtask

    initial begin
        prog3_en[0] = E_RA | E_WT;
        prog3_en[1] = E_RA | E_S | E_WAC;
        prog3_en[2] = E_RAC | E_WC;

        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; len = '0; reps = '0; abort = 1'b0;
        #12;
        checkOutput("reset_en", 16'(en), 16'(E_OFF));
        checkOutput("reset_flags", {13'd0, busy, done, err}, 16'd0);
        checkOutput("reset_pc", 16'(pc), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        stepCycle();

        // Basic three-op program, one pass
        loadOp(4'd0, 8'h30);
        loadOp(4'd1, 8'h36);
        loadOp(4'd2, 8'h8C);
        applyStimulus(5'd3, 4'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("p1_en%0d", i), 16'(en), 16'(prog3_en[i]));
            checkOutput($sformatf("p1_pc%0d", i), 16'(pc), 16'(i));
            checkOutput($sformatf("p1_busy%0d", i), {15'd0, busy}, 16'd1);
            stepCycle();
        end
        checkOutput("p1_done", {14'd0, busy, done}, 16'b01);
        checkOutput("p1_done_en", 16'(en), 16'(E_OFF));
        stepCycle();
        checkOutput("p1_idle", {14'd0, busy, done}, 16'b00);

        // Three passes
        applyStimulus(5'd3, 4'd3);
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("p3_pc%0d", i), 16'(pc), 16'(i % 3));
            checkOutput($sformatf("p3_en%0d", i), 16'(en), 16'(prog3_en[i % 3]));
            checkOutput($sformatf("p3_flags%0d", i), {14'd0, busy, done}, 16'b10);
            stepCycle();
        end
        checkOutput("p3_done", {14'd0, busy, done}, 16'b01);
        stepCycle();

        // reps=0 behaves as one pass
        applyStimulus(5'd3, 4'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("r0_pc%0d", i), 16'(pc), 16'(i));
            checkOutput($sformatf("r0_busy%0d", i), {15'd0, busy}, 16'd1);
            stepCycle();
        end
        checkOutput("r0_done", {14'd0, busy, done}, 16'b01);
        stepCycle();

        // len=0 goes straight to done
        applyStimulus(5'd0, 4'd1);
        checkOutput("l0_done", {13'd0, busy, done, err}, 16'b010);
        stepCycle();

        // Illegal ALU code at address 1
        loadOp(4'd1, 8'h37);
        applyStimulus(5'd2, 4'd1);
        checkOutput("ill_en0", 16'(en), 16'(E_RA | E_WT));
        stepCycle();
        checkOutput("ill_en1", 16'(en), 16'(E_OFF));
        checkOutput("ill_pc1", 16'(pc), 16'd1);
        stepCycle();
        checkOutput("ill_err", {13'd0, busy, done, err}, 16'b001);
        checkOutput("ill_err_pc", 16'(pc), 16'd1);
        checkOutput("ill_err_en", 16'(en), 16'(E_OFF));
        stepCycle();
        checkOutput("ill_err_hold", {15'd0, err}, 16'd1);
        applyStimulus(5'd2, 4'd1);
        checkOutput("ill_exit", {13'd0, busy, done, err}, 16'b000);
        stepCycle();
        checkOutput("ill_no_run", {13'd0, busy, done, err}, 16'b000);

        // Pass-through into AC is illegal
        loadOp(4'd0, 8'h34);
        applyStimulus(5'd1, 4'd1);
        checkOutput("pass_ac_en", 16'(en), 16'(E_OFF));
        stepCycle();
        checkOutput("pass_ac_err", {13'd0, busy, done, err}, 16'b001);
        checkOutput("pass_ac_pc", 16'(pc), 16'd0);
        pulseAbort();
        checkOutput("pass_ac_abort", {15'd0, err}, 16'd0);

        // Write without a source is illegal
        loadOp(4'd0, 8'h0C);
        applyStimulus(5'd1, 4'd1);
        checkOutput("nosrc_en", 16'(en), 16'(E_OFF));
        stepCycle();
        checkOutput("nosrc_err", {13'd0, busy, done, err}, 16'b001);
        pulseAbort();

        // Long run aborted in cycle 5, with a dropped program write in cycle 3
        loadOp(4'd0, 8'h30);
        loadOp(4'd1, 8'h36);
        loadOp(4'd4, 8'h30);
        applyStimulus(5'd16, 4'd2);
        for (int c = 1; c <= 4; c++) begin
            checkOutput($sformatf("ab_pc%0d", c), 16'(pc), 16'(c - 1));
            if (c == 3) begin
                prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h37;
            end else begin
                prog_we = 1'b0;
            end
            stepCycle();
        end
        abort = 1'b1;
        checkOutput("ab_c5_pc", 16'(pc), 16'd4);
        checkOutput("ab_c5_en", 16'(en), 16'(E_RA | E_WT));
        checkOutput("ab_c5_busy", {15'd0, busy}, 16'd1);
        stepCycle();
        abort = 1'b0;
        checkOutput("ab_c6_idle", {13'd0, busy, done, err}, 16'b000);
        checkOutput("ab_c6_en", 16'(en), 16'(E_OFF));
        stepCycle();
        checkOutput("ab_c7_nodone", {15'd0, done}, 16'd0);
        applyStimulus(5'd1, 4'd1);
        checkOutput("ab_mem_kept", 16'(en), 16'(E_RA | E_WT));
        stepCycle();
        checkOutput("ab_mem_done", {13'd0, busy, done, err}, 16'b010);
        stepCycle();

        // Asynchronous reset in cycle 2 of a run
        loadOp(4'd1, 8'h36);
        applyStimulus(5'd3, 4'd1);
        checkOutput("ar_c1", 16'(en), 16'(E_RA | E_WT));
        stepCycle();
        checkOutput("ar_c2", 16'(en), 16'(E_RA | E_S | E_WAC));
        #1 reset = 1'b1;
        #1;
        checkOutput("ar_en", 16'(en), 16'(E_OFF));
        checkOutput("ar_flags", {13'd0, busy, done, err}, 16'd0);
        checkOutput("ar_pc", 16'(pc), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        stepCycle();
        applyStimulus(5'd1, 4'd1);
        checkOutput("ar_run_en", 16'(en), 16'(E_OFF));
        checkOutput("ar_run_busy", {15'd0, busy}, 16'd1);
        stepCycle();
        checkOutput("ar_run_done", {13'd0, busy, done, err}, 16'b010);
        stepCycle();
        applyStimulus(5'd3, 4'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("ar_clr_en%0d", i), 16'(en), 16'(E_OFF));
            stepCycle();
        end
        checkOutput("ar_clr_done", {13'd0, busy, done, err}, 16'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
